seq_alu: RTL

Parametrised multi-cycle ALU for the datapath. It extends the single-cycle opcode-driven ALU with a start/done handshake, and adds a sequential signed multiplier and an optional sequential signed divider. Results are returned in a double-width C register (HI:LO) that the datapath splits into its HI/LO registers. It sits between the operand registers (A from bus/Y, B from bus) and the Z/HI/LO capture logic, and is driven by the control unit.

---
 rtl/seq_alu.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle ops, Booth multiplier, optional divider
// Define SEQ_ALU_DIV_EN to build the signed non-restoring divider (DIV/FIX states, div_by_zero).
module seq_alu #(
   parameter int wordSize = 32
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    start,
   input  logic [4:0]              opcode,
   input  logic [wordSize-1:0]     A,
   input  logic [wordSize-1:0]     B,
   output logic [2*wordSize-1:0]   C,
   output logic                    busy,
   output logic                    done,
   output logic                    div_by_zero
);
   localparam int W   = wordSize;
   localparam int SHW = $clog2(W);
   localparam int CW  = $clog2(W + 1);

   localparam logic [4:0] OP_ADD  = 5'd1;
   localparam logic [4:0] OP_SUB  = 5'd2;
   localparam logic [4:0] OP_AND  = 5'd3;
   localparam logic [4:0] OP_OR   = 5'd4;
   localparam logic [4:0] OP_SHR  = 5'd5;
   localparam logic [4:0] OP_SHRA = 5'd6;
   localparam logic [4:0] OP_SHL  = 5'd7;
   localparam logic [4:0] OP_ROR  = 5'd8;
   localparam logic [4:0] OP_ROL  = 5'd9;
   localparam logic [4:0] OP_MUL  = 5'd10;
   localparam logic [4:0] OP_DIV  = 5'd11;
   localparam logic [4:0] OP_NEG  = 5'd12;
   localparam logic [4:0] OP_NOT  = 5'd13;

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_FIX} state_t;

   state_t          state_q;
   logic [4:0]      op_q;
   logic [W-1:0]    a_q, b_q;
   logic [CW-1:0]   cnt_q;
   logic [2*W+1:0]  p_q, p_d;
   logic [2*W-1:0]  c_q;
   logic            busy_q, done_q;

   logic [SHW-1:0]  sh_amt;
   logic [2*W-1:0]  rot_r, rot_l;
   logic [W-1:0]    alu_d;
   logic [W:0]      m_ext, hi_sum;

   assign sh_amt = b_q[SHW-1:0];
   assign rot_r  = {a_q, a_q} >> sh_amt;
   assign rot_l  = {a_q, a_q} << sh_amt;

   always_comb begin
      alu_d = '0;
      case (op_q)
         OP_ADD:  alu_d = a_q + b_q;
         OP_SUB:  alu_d = a_q - b_q;
         OP_AND:  alu_d = a_q & b_q;
         OP_OR:   alu_d = a_q | b_q;
         OP_SHR:  alu_d = a_q >> sh_amt;
         OP_SHRA: alu_d = $signed(a_q) >>> sh_amt;
         OP_SHL:  alu_d = a_q << sh_amt;
         OP_ROR:  alu_d = rot_r[W-1:0];
         OP_ROL:  alu_d = rot_l[2*W-1:W];
         OP_NEG:  alu_d = ~b_q + W'(1);
         OP_NOT:  alu_d = ~b_q;
         default: alu_d = '0;
      endcase
   end

   // Booth step: p_q = {hi[W:0], multiplier[W-1:0], q(-1)}, hi kept one bit wide to absorb MIN*MIN
   assign m_ext = {a_q[W-1], a_q};

   always_comb begin
      hi_sum = p_q[2*W+1:W+1];
      case (p_q[1:0])
         2'b01:   hi_sum = p_q[2*W+1:W+1] + m_ext;
         2'b10:   hi_sum = p_q[2*W+1:W+1] - m_ext;
         default: hi_sum = p_q[2*W+1:W+1];
      endcase
      p_d = {hi_sum[W], hi_sum, p_q[W:1]};
   end

`ifdef SEQ_ALU_DIV_EN
   logic [W+1:0]  r_q, r_d, r_sh, dv_ext;
   logic [W-1:0]  qt_q, qt_d, dv_q;
   logic [W-1:0]  quo_fix, rem_fix;
   logic          dbz_q;

   function automatic logic [W-1:0] mag(input logic [W-1:0] v);
      return v[W-1] ? (~v + W'(1)) : v;
   endfunction

   // Non-restoring step on magnitudes; quotient bit is the sign of the new partial remainder
   assign dv_ext = {2'b00, dv_q};
   assign r_sh   = {r_q[W:0], qt_q[W-1]};
   assign r_d    = r_q[W+1] ? (r_sh + dv_ext) : (r_sh - dv_ext);
   assign qt_d   = {qt_q[W-2:0], ~r_d[W+1]};

   assign quo_fix = (a_q[W-1] ^ b_q[W-1]) ? (~qt_q + W'(1)) : qt_q;
   assign rem_fix = a_q[W-1] ? (~r_q[W-1:0] + W'(1)) : r_q[W-1:0];
   assign div_by_zero = dbz_q;
`else
   assign div_by_zero = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         c_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
         r_q     <= '0;
         qt_q    <= '0;
         dv_q    <= '0;
         dbz_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q  <= opcode;
                  a_q   <= A;
                  b_q   <= B;
                  cnt_q <= '0;
`ifdef SEQ_ALU_DIV_EN
                  dbz_q <= 1'b0;
`endif
                  if (opcode == OP_MUL) begin
                     p_q     <= {{(W+1){1'b0}}, B, 1'b0};
                     busy_q  <= 1'b1;
                     state_q <= S_MUL;
`ifdef SEQ_ALU_DIV_EN
                  end else if (opcode == OP_DIV) begin
                     r_q     <= '0;
                     qt_q    <= mag(A);
                     dv_q    <= mag(B);
                     busy_q  <= 1'b1;
                     state_q <= S_DIV;
`endif
                  end else begin
                     state_q <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               c_q     <= {{W{1'b0}}, alu_d};
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            S_MUL: begin
               if (cnt_q == CW'(W)) begin
                  c_q     <= p_q[2*W:1];
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  p_q   <= p_d;
                  cnt_q <= cnt_q + CW'(1);
               end
            end
`ifdef SEQ_ALU_DIV_EN
            S_DIV: begin
               if (cnt_q == CW'(W)) begin
                  if (r_q[W+1]) r_q <= r_q + dv_ext;
                  state_q <= S_FIX;
               end else begin
                  if (dv_q != '0) begin
                     r_q  <= r_d;
                     qt_q <= qt_d;
                  end
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_FIX: begin
               if (b_q == '0) begin
                  c_q   <= {a_q, {W{1'b1}}};
                  dbz_q <= 1'b1;
               end else begin
                  c_q <= {rem_fix, quo_fix};
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
`endif
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign C    = c_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
